regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single write port of the 4x32 register file between two writeback requesters (req0 = ALU writeback, req1 = load writeback) using round-robin arbitration and valid/ready handshakes. Accepted writes pass through one registered issue stage that drives WriteReg/WriteData/RegWrite. Both read ports are bypassed from that stage, so a consumer never reads a stale value during the write cycle.

Parameters:
DATA_W, 32, width of write/read data
ADDR_W, 2, register index width (2**ADDR_W registers)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a write pending
req0_ready  output  1  requester 0 write accepted this cycle
req0_reg  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req1_valid  input  1  requester 1 has a write pending
req1_ready  output  1  requester 1 write accepted this cycle
req1_reg  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
rf_write_reg  output  ADDR_W  to regfile WriteReg
rf_write_data  output  DATA_W  to regfile WriteData
rf_reg_write  output  1  to regfile RegWrite
rd_reg1  input  ADDR_W  read index, port 1 (also driven to regfile ReadReg1)
rd_reg2  input  ADDR_W  read index, port 2 (also driven to regfile ReadReg2)
rf_read_data1  input  DATA_W  regfile ReadData1
rf_read_data2  input  DATA_W  regfile ReadData2
rd_data1  output  DATA_W  bypassed read data, port 1
rd_data2  output  DATA_W  bypassed read data, port 2

Behaviour:
- Reset (reset=0, async): stage_valid=0, rf_reg_write=0, rf_write_reg=0, rf_write_data=0, prio=0 (req0 favoured); req0_ready/req1_ready=0 while reset is asserted.
- Arbitration (combinational): req0_ready = req0_valid & (~req1_valid | prio==0); req1_ready = req1_valid & (~req0_valid | prio==1). At most one ready per cycle. The ready signals depend on valid by design; requesters must not make valid depend on ready.
- Requester rule: once valid is asserted, reg/data are held stable and valid stays high until the ready cycle.
- Priority update: on the clock edge after a grant, prio becomes the index of the non-granted requester. No grant leaves prio unchanged. A requester with valid held waits at most 1 grant.
- Issue stage: on the edge ending a grant cycle N, the stage captures {reg, data} of the winner and sets stage_valid=1. During cycle N+1, rf_reg_write=1 and rf_write_reg/rf_write_data show the captured values. The regfile commits on the edge ending N+1. With no grant, stage_valid=0 and rf_reg_write=0; rf_write_reg/rf_write_data hold their last values.
- Throughput: one write per cycle. The regfile never back-pressures, so the stage drains every cycle and no stall path exists.
- Latency: handshake in cycle N; rf_read_data reflects the new value from cycle N+2; rd_data reflects it from cycle N+1 through the bypass.
- Bypass: rd_dataX = (stage_valid & rd_regX==rf_write_reg) ? rf_write_data : rf_read_dataX. Purely combinational, evaluated independently per port. Both ports may hit simultaneously.
- Same-register collision: if both requesters target the same register in one cycle, they are serialised by grant order. The later grant's data is final.
- Back-to-back writes to the same register: the stage always holds the newest value, so the bypass returns the newest value.
- Reset mid-operation: a write held in the stage is discarded (rf_reg_write forced 0). Requesters' pending valids are re-arbitrated from prio=0 after reset release.

Decomposition:
- Shared package/header: DATA_W and ADDR_W defaults, requester index constants REQ_ALU=0 and REQ_LOAD=1.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter containing the prio flop, with inputs valid[1:0] and outputs grant[1:0].
- Issue stage and bypass muxes stay in the top block.

Test Plan:
1. Reset low for 2 cycles with req0_valid=1 -> req0_ready=0 and rf_reg_write=0 throughout; after release, req0 granted in the first cycle.
2. req0 writes reg0=32'hFFFFFFFF alone -> req0_ready=1 in cycle N; rf_reg_write=1 with rf_write_reg=0 in N+1; rd_reg1=0 gives rd_data1=FFFFFFFF in N+1 (bypass) and in N+2 (regfile).
3. req0 (reg2=32'hAAAAAAAA) and req1 (reg3=32'h55555555) held valid together from reset -> grants alternate req0 then req1; reg2 then reg3 written on consecutive cycles; prio returns to 0.
4. Both requesters target reg1, with req0=32'h11111111 and req1=32'h22222222, prio=0 -> final reg1 and rd_data1 = 22222222; in between, rd_data1 shows 11111111 for one cycle.
5. rd_reg1=rd_reg2=2 while stage holds reg2=32'hCAFEF00D -> both rd_data1 and rd_data2 = CAFEF00D while rf_read_data still old; rd_reg2=3 -> rd_data2 = rf_read_data2.
6. Assert reset in the cycle after a grant of reg1=32'h12345678 -> rf_reg_write=0 immediately; after release, reg1 reads 0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the regfile write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_ADDR_W = 2;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  typedef enum logic {
    PRIO_ALU  = 1'b0,
    PRIO_LOAD = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requesters, regfile write/read port and bypassed read data.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;

  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_reg_write;

  logic [ADDR_W-1:0] rd_reg1;
  logic [ADDR_W-1:0] rd_reg2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  rd_reg1, rd_reg2, rf_read_data1, rf_read_data2,
    output req0_ready, req1_ready,
    output rf_write_reg, rf_write_data, rf_reg_write,
    output rd_data1, rd_data2
  );

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output rd_reg1, rd_reg2, rf_read_data1, rf_read_data2,
    input  req0_ready, req1_ready,
    input  rf_write_reg, rf_write_data, rf_reg_write,
    input  rd_data1, rd_data2
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the loser of a grant is favoured next time.
module rr_arb2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  // state     | meaning
  // PRIO_ALU  | req0 (ALU) wins a simultaneous request
  // PRIO_LOAD | req1 (load) wins a simultaneous request
  prio_e prio_q, prio_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_q <= PRIO_ALU;
    else        prio_q <= prio_d;
  end

  // Grants are held off while reset is asserted so no handshake completes.
  always_comb begin
    grant_o = 2'b00;
    prio_d  = prio_q;
    if (reset) begin
      grant_o[REQ_ALU]  = valid_i[REQ_ALU]  & (~valid_i[REQ_LOAD] | (prio_q == PRIO_ALU));
      grant_o[REQ_LOAD] = valid_i[REQ_LOAD] & (~valid_i[REQ_ALU]  | (prio_q == PRIO_LOAD));
    end
    if (grant_o[REQ_ALU])       prio_d = PRIO_LOAD;
    else if (grant_o[REQ_LOAD]) prio_d = PRIO_ALU;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the regfile write port between ALU and load writeback,
// with a one-deep issue stage and per-port read bypass from that stage.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] stage_reg_q, stage_reg_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;

  assign valid[REQ_ALU]  = bus.req0_valid;
  assign valid[REQ_LOAD] = bus.req1_valid;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid),
    .grant_o (grant)
  );

  assign bus.req0_ready = grant[REQ_ALU];
  assign bus.req1_ready = grant[REQ_LOAD];

  // The regfile never stalls, so the stage simply reloads every cycle.
  always_comb begin
    stage_valid_d = |grant;
    stage_reg_d   = stage_reg_q;
    stage_data_d  = stage_data_q;
    if (grant[REQ_ALU]) begin
      stage_reg_d  = bus.req0_reg;
      stage_data_d = bus.req0_data;
    end else if (grant[REQ_LOAD]) begin
      stage_reg_d  = bus.req1_reg;
      stage_data_d = bus.req1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_reg_q   <= '0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_reg_q   <= stage_reg_d;
      stage_data_q  <= stage_data_d;
    end
  end

  assign bus.rf_reg_write  = stage_valid_q;
  assign bus.rf_write_reg  = stage_reg_q;
  assign bus.rf_write_data = stage_data_q;

  // The regfile only commits at the end of the stage cycle, so a hit must be forwarded.
  assign bus.rd_data1 = (stage_valid_q && bus.rd_reg1 == stage_reg_q) ? stage_data_q
                                                                      : bus.rf_read_data1;
  assign bus.rd_data2 = (stage_valid_q && bus.rd_reg2 == stage_reg_q) ? stage_data_q
                                                                      : bus.rf_read_data2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an architectural model.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fixture: commits on rf_reg_write, cleared by reset.
  logic [31:0] rf_mem [4];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 32'h0;
    end else if (bus.rf_reg_write) begin
      rf_mem[bus.rf_write_reg] <= bus.rf_write_data;
    end
  end
  assign bus.rf_read_data1 = rf_mem[bus.rd_reg1];
  assign bus.rf_read_data2 = rf_mem[bus.rd_reg2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Architectural model: a write becomes visible to readers the cycle after its
  // handshake; the regfile output port shows the most recently accepted write.
  int          m_prio;
  bit          m_we;
  logic [1:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_arch [4];

  initial begin
    m_prio = 0; m_we = 0; m_wreg = 2'd0; m_wdata = 32'h0;
    for (int i = 0; i < 4; i++) m_arch[i] = 32'h0;
  end

  always @(negedge clk) begin
    bit want0, want1, win0, win1;
    if (!reset) begin
      chk1("rst_ready0", bus.req0_ready, 1'b0);
      chk1("rst_ready1", bus.req1_ready, 1'b0);
      chk1("rst_we", bus.rf_reg_write, 1'b0);
      m_prio = 0; m_we = 0; m_wreg = 2'd0; m_wdata = 32'h0;
      for (int i = 0; i < 4; i++) m_arch[i] = 32'h0;
    end else begin
      want0 = bus.req0_valid;
      want1 = bus.req1_valid;
      if (want0 && want1) begin
        win0 = (m_prio == 0);
        win1 = (m_prio == 1);
      end else begin
        win0 = want0;
        win1 = want1;
      end
      chk1("ready0", bus.req0_ready, win0);
      chk1("ready1", bus.req1_ready, win1);
      chk1("rf_reg_write", bus.rf_reg_write, m_we);
      chk("rf_write_reg", 32'(bus.rf_write_reg), 32'(m_wreg));
      chk("rf_write_data", bus.rf_write_data, m_wdata);
      chk("rd_data1", bus.rd_data1, m_arch[bus.rd_reg1]);
      chk("rd_data2", bus.rd_data2, m_arch[bus.rd_reg2]);
      m_we = win0 || win1;
      if (win0) begin
        m_wreg = bus.req0_reg; m_wdata = bus.req0_data;
        m_arch[bus.req0_reg] = bus.req0_data; m_prio = 1;
      end else if (win1) begin
        m_wreg = bus.req1_reg; m_wdata = bus.req1_data;
        m_arch[bus.req1_reg] = bus.req1_data; m_prio = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int order [$];

  task automatic drain(input int max_cycles);
    bit g0, g1;
    int n = 0;
    while ((bus.req0_valid || bus.req1_valid) && n < max_cycles) begin
      @(negedge clk);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      if (g0) order.push_back(0);
      if (g1) order.push_back(1);
      step();
      if (g0) bus.req0_valid = 1'b0;
      if (g1) bus.req1_valid = 1'b0;
      n++;
    end
    chk1("drain_timeout", bus.req0_valid || bus.req1_valid, 1'b0);
  endtask

  initial begin
    bit g0, g1;
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_reg = 2'd0; bus.req0_data = 32'hFFFF_FFFF;
    bus.req1_valid = 1'b0; bus.req1_reg = 2'd0; bus.req1_data = 32'h0;
    bus.rd_reg1 = 2'd0; bus.rd_reg2 = 2'd1;

    // Reset held with a pending request, then first grant and bypass latency.
    repeat (2) begin
      @(negedge clk);
      chk1("t1_ready_in_reset", bus.req0_ready, 1'b0);
      chk1("t1_we_in_reset", bus.rf_reg_write, 1'b0);
    end
    step(); reset = 1'b1;
    @(negedge clk); chk1("t1_grant_after_release", bus.req0_ready, 1'b1);
    step(); bus.req0_valid = 1'b0;
    @(negedge clk);
    chk1("t2_we", bus.rf_reg_write, 1'b1);
    chk("t2_wreg", 32'(bus.rf_write_reg), 32'd0);
    chk("t2_bypass", bus.rd_data1, 32'hFFFF_FFFF);
    step();
    @(negedge clk);
    chk("t2_from_rf", bus.rd_data1, 32'hFFFF_FFFF);
    chk1("t2_we_off", bus.rf_reg_write, 1'b0);

    // Both held from reset: alternate starting with req0.
    step(); reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_reg = 2'd2; bus.req0_data = 32'hAAAA_AAAA;
    bus.req1_valid = 1'b1; bus.req1_reg = 2'd3; bus.req1_data = 32'h5555_5555;
    step(); reset = 1'b1;
    order.delete();
    drain(8);
    chk("t3_n_grants", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("t3_first", 32'(order[0]), 32'd0);
      chk("t3_second", 32'(order[1]), 32'd1);
    end
    bus.rd_reg1 = 2'd2; bus.rd_reg2 = 2'd3;
    @(negedge clk);
    chk("t3_reg2", bus.rd_data1, 32'hAAAA_AAAA);
    chk("t3_reg3", bus.rd_data2, 32'h5555_5555);

    // Same-register collision; req0 first shows prio came back to req0.
    step();
    bus.req0_valid = 1'b1; bus.req0_reg = 2'd1; bus.req0_data = 32'h1111_1111;
    bus.req1_valid = 1'b1; bus.req1_reg = 2'd1; bus.req1_data = 32'h2222_2222;
    bus.rd_reg1 = 2'd1;
    @(negedge clk);
    chk1("t4_r0_first", bus.req0_ready, 1'b1);
    chk1("t4_r1_waits", bus.req1_ready, 1'b0);
    step(); bus.req0_valid = 1'b0;
    @(negedge clk);
    chk1("t4_r1_next", bus.req1_ready, 1'b1);
    chk("t4_mid", bus.rd_data1, 32'h1111_1111);
    step(); bus.req1_valid = 1'b0;
    @(negedge clk); chk("t4_final_byp", bus.rd_data1, 32'h2222_2222);
    step();
    @(negedge clk); chk("t4_final_rf", bus.rd_data1, 32'h2222_2222);

    // Dual-port bypass hit while the regfile still holds the old value.
    step();
    bus.rd_reg1 = 2'd2; bus.rd_reg2 = 2'd2;
    bus.req1_valid = 1'b1; bus.req1_reg = 2'd2; bus.req1_data = 32'hCAFE_F00D;
    @(negedge clk); chk1("t5_grant", bus.req1_ready, 1'b1);
    step(); bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("t5_port1", bus.rd_data1, 32'hCAFE_F00D);
    chk("t5_port2", bus.rd_data2, 32'hCAFE_F00D);
    chk("t5_rf_old", bus.rf_read_data1, 32'hAAAA_AAAA);
    #1 bus.rd_reg2 = 2'd3;
    #1 chk("t5_port2_miss", bus.rd_data2, 32'h5555_5555);

    // Reset right after a grant discards the staged write.
    step();
    bus.req0_valid = 1'b1; bus.req0_reg = 2'd1; bus.req0_data = 32'h1234_5678;
    bus.rd_reg1 = 2'd1;
    @(negedge clk); chk1("t6_grant", bus.req0_ready, 1'b1);
    step(); bus.req0_valid = 1'b0; reset = 1'b0;
    #1 chk1("t6_we_killed", bus.rf_reg_write, 1'b0);
    step(); reset = 1'b1;
    @(negedge clk); chk("t6_reg1_zero", bus.rd_data1, 32'h0);

    // Randomized traffic honouring the hold-until-ready rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      step();
      reset = ($urandom_range(199) != 0);
      if (!bus.req0_valid || g0) begin
        bus.req0_valid = ($urandom_range(2) != 0);
        bus.req0_reg   = 2'($urandom_range(3));
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || g1) begin
        bus.req1_valid = ($urandom_range(2) != 0);
        bus.req1_reg   = 2'($urandom_range(3));
        bus.req1_data  = $urandom;
      end
      bus.rd_reg1 = 2'($urandom_range(3));
      bus.rd_reg2 = 2'($urandom_range(3));
    end
    reset = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
